// File: rtl/ex_stage.sv
// Execute stage: consumes the ID/EX bundle, runs the ALU or the iterative
// shift-add multiplier, resolves branches and drives the EX/MEM register.
//
// state | meaning
// IDLE  | single-cycle ops flow through; a valid MUL is accepted here
// MUL   | shift-add iterations in progress, upstream held by stall
module ex_stage #(
   parameter int WIDTH      = 16,
   parameter int REGW       = 4,
   parameter int MUL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             flush,
   input  logic             regwrite,
   input  logic             memread,
   input  logic             memwrite,
   input  logic             branch,
   input  logic             memtoreg,
   input  logic             regdst,
   input  logic             alusrc,
   input  logic [2:0]       aluop,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [WIDTH-1:0] offset,
   input  logic [WIDTH-1:0] pcplus,
   input  logic [REGW-1:0]  regdest1,
   input  logic [REGW-1:0]  regdest2,
   output logic             stall,
   output logic             valid_out,
   output logic             regwriteout,
   output logic             memreadout,
   output logic             memwriteout,
   output logic             memtoregout,
   output logic             branch_taken,
   output logic [WIDTH-1:0] branch_target,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] store_data,
   output logic [REGW-1:0]  wreg
);

   typedef enum logic {IDLE, MUL} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_NOR = 3'b111;

   localparam int CW = $clog2(MUL_CYCLES);
   localparam int SW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;

   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_comb;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] target_comb;
   logic [REGW-1:0]  wreg_comb;
   logic             operands_eq;
   logic             mul_accept;

   assign op_b        = alusrc ? offset : data2;
   assign wreg_comb   = regdst ? regdest2 : regdest1;
   assign target_comb = pcplus + offset;
   assign operands_eq = (data1 == data2);
   assign acc_next    = mplier[0] ? (acc + mcand) : acc;
   assign mul_accept  = in_valid && (aluop == OP_MUL);

   // Single-cycle ALU result; MUL is produced by the iterative path instead.
   always_comb begin
      alu_comb = '0;
      case (aluop)
         OP_ADD: alu_comb = data1 + op_b;
         OP_SUB: alu_comb = data1 - op_b;
         OP_AND: alu_comb = data1 & op_b;
         OP_OR:  alu_comb = data1 | op_b;
         OP_SLT: alu_comb = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(op_b))};
         OP_SLL: alu_comb = data1 << op_b[SW-1:0];
         OP_MUL: alu_comb = '0;
         OP_NOR: alu_comb = ~(data1 | op_b);
         default: alu_comb = '0;
      endcase
   end

   // Hold upstream during the accept cycle and all but the last iteration.
   always_comb begin
      stall = 1'b0;
      if (rst_n && !flush) begin
         if (state == IDLE) stall = mul_accept;
         else               stall = (cnt != CNT_LAST);
      end
   end

   // FSM, multiplier datapath and EX/MEM register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         mcand         <= '0;
         mplier        <= '0;
         acc           <= '0;
         valid_out     <= 1'b0;
         regwriteout   <= 1'b0;
         memreadout    <= 1'b0;
         memwriteout   <= 1'b0;
         memtoregout   <= 1'b0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
         alu_result    <= '0;
         store_data    <= '0;
         wreg          <= '0;
      end else if (flush) begin
         state        <= IDLE;
         cnt          <= '0;
         acc          <= '0;
         valid_out    <= 1'b0;
         regwriteout  <= 1'b0;
         memreadout   <= 1'b0;
         memwriteout  <= 1'b0;
         memtoregout  <= 1'b0;
         branch_taken <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mul_accept) begin
                  mcand        <= data1;
                  mplier       <= op_b;
                  acc          <= '0;
                  cnt          <= '0;
                  state        <= MUL;
                  valid_out    <= 1'b0;
                  regwriteout  <= 1'b0;
                  memreadout   <= 1'b0;
                  memwriteout  <= 1'b0;
                  memtoregout  <= 1'b0;
                  branch_taken <= 1'b0;
               end else begin
                  valid_out    <= in_valid;
                  regwriteout  <= regwrite & in_valid;
                  memreadout   <= memread & in_valid;
                  memwriteout  <= memwrite & in_valid;
                  memtoregout  <= memtoreg & in_valid;
                  branch_taken <= branch & operands_eq & in_valid;
                  // Bubbles leave the data fields untouched.
                  if (in_valid) begin
                     alu_result    <= alu_comb;
                     branch_target <= target_comb;
                     store_data    <= data2;
                     wreg          <= wreg_comb;
                  end
               end
            end
            MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               if (cnt == CNT_LAST) begin
                  cnt           <= '0;
                  state         <= IDLE;
                  valid_out     <= 1'b1;
                  regwriteout   <= regwrite;
                  memreadout    <= memread;
                  memwriteout   <= memwrite;
                  memtoregout   <= memtoreg;
                  branch_taken  <= 1'b0;
                  alu_result    <= acc_next;
                  branch_target <= target_comb;
                  store_data    <= data2;
                  wreg          <= wreg_comb;
               end else begin
                  cnt          <= cnt + CW'(1);
                  valid_out    <= 1'b0;
                  regwriteout  <= 1'b0;
                  memreadout   <= 1'b0;
                  memwriteout  <= 1'b0;
                  memtoregout  <= 1'b0;
                  branch_taken <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver issues instructions and pushes the
// expected EX/MEM contents; a negedge monitor pops and compares.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, flush;
   logic        regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc;
   logic [2:0]  aluop;
   logic [15:0] data1, data2, offset, pcplus;
   logic [3:0]  regdest1, regdest2;
   logic        stall, valid_out, regwriteout, memreadout, memwriteout, memtoregout;
   logic        branch_taken;
   logic [15:0] branch_target, alu_result, store_data;
   logic [3:0]  wreg;

   ex_stage #(.WIDTH(16), .REGW(4), .MUL_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
      .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
      .branch(branch), .memtoreg(memtoreg), .regdst(regdst), .alusrc(alusrc),
      .aluop(aluop), .data1(data1), .data2(data2), .offset(offset),
      .pcplus(pcplus), .regdest1(regdest1), .regdest2(regdest2),
      .stall(stall), .valid_out(valid_out), .regwriteout(regwriteout),
      .memreadout(memreadout), .memwriteout(memwriteout),
      .memtoregout(memtoregout), .branch_taken(branch_taken),
      .branch_target(branch_target), .alu_result(alu_result),
      .store_data(store_data), .wreg(wreg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        in_valid, regwrite, memread, memwrite, branch, memtoreg, regdst, alusrc;
      logic [2:0]  aluop;
      logic [15:0] data1, data2, offset, pcplus;
      logic [3:0]  rd1, rd2;
   } instr_t;

   typedef struct {
      logic        regwrite, memread, memwrite, memtoreg, taken;
      logic [15:0] target, result, store;
      logic [3:0]  wreg;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Reference behaviour of one retired instruction, straight from the ISA rules.
   function automatic exp_t model(input instr_t i);
      exp_t        e;
      logic [15:0] b;
      logic [31:0] prod;
      b = i.alusrc ? i.offset : i.data2;
      prod = 32'(i.data1) * 32'(b);
      case (i.aluop)
         3'd0: e.result = i.data1 + b;
         3'd1: e.result = i.data1 - b;
         3'd2: e.result = i.data1 & b;
         3'd3: e.result = i.data1 | b;
         3'd4: e.result = ($signed(i.data1) < $signed(b)) ? 16'd1 : 16'd0;
         3'd5: e.result = i.data1 << (b % 16);
         3'd6: e.result = prod[15:0];
         default: e.result = ~(i.data1 | b);
      endcase
      e.regwrite = i.regwrite;
      e.memread  = i.memread;
      e.memwrite = i.memwrite;
      e.memtoreg = i.memtoreg;
      e.taken    = i.branch && (i.data1 == i.data2) && (i.aluop != 3'd6);
      e.target   = i.pcplus + i.offset;
      e.store    = i.data2;
      e.wreg     = i.regdst ? i.rd2 : i.rd1;
      return e;
   endfunction

   function automatic instr_t mk(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      instr_t i;
      i.in_valid = 1'b1; i.regwrite = 1'b1; i.memread = 1'b0; i.memwrite = 1'b0;
      i.branch = 1'b0; i.memtoreg = 1'b0; i.regdst = 1'b0; i.alusrc = 1'b0;
      i.aluop = op; i.data1 = a; i.data2 = b;
      i.offset = 16'($urandom); i.pcplus = 16'($urandom);
      i.rd1 = 4'($urandom); i.rd2 = 4'($urandom);
      return i;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t i;
      i = mk(3'($urandom), 16'($urandom), 16'($urandom));
      i.in_valid = ($urandom_range(0, 9) != 0);
      {i.regwrite, i.memread, i.memwrite, i.branch, i.memtoreg, i.regdst, i.alusrc} = 7'($urandom);
      if ($urandom_range(0, 3) == 0) i.data2 = i.data1;
      if ($urandom_range(0, 3) == 0) i.aluop = 3'd6;
      return i;
   endfunction

   task automatic apply(input instr_t i);
      in_valid = i.in_valid; regwrite = i.regwrite; memread = i.memread;
      memwrite = i.memwrite; branch = i.branch; memtoreg = i.memtoreg;
      regdst = i.regdst; alusrc = i.alusrc; aluop = i.aluop;
      data1 = i.data1; data2 = i.data2; offset = i.offset; pcplus = i.pcplus;
      regdest1 = i.rd1; regdest2 = i.rd2;
   endtask

   task automatic chk_zero(input string name);
      chk(name, {valid_out, regwriteout, memreadout, memwriteout, memtoregout,
                 branch_taken, branch_target, alu_result, store_data, wreg}, 64'd0);
   endtask

   // Present one instruction (called at posedge+1) and hold it while stalled.
   // flush_at: cycle index within this instruction at which flush is raised.
   task automatic run(input instr_t ins, input int flush_at);
      int  nst = 0;
      int  want;
      bit  done = 0;
      logic st;
      apply(ins);
      for (int c = 0; c < 40 && !done; c++) begin
         flush = (c == flush_at);
         @(negedge clk); #1;
         st = stall;
         if (st) nst++;
         if (!st && ins.in_valid && !flush) q.push_back(model(ins));
         @(posedge clk); #1;
         if (!st) done = 1;
      end
      flush = 1'b0;
      if (!done) chk("run_timeout", 0, 1);
      if (ins.in_valid && ins.aluop == 3'd6) want = (flush_at >= 0 && flush_at <= 16) ? flush_at : 16;
      else want = 0;
      chk("stall_cycles", nst, want);
   endtask

   // Monitor: one expected entry per edge that retired an instruction.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("valid_out", valid_out, 1);
         chk("ctrl", {regwriteout, memreadout, memwriteout, memtoregout},
             {e.regwrite, e.memread, e.memwrite, e.memtoreg});
         chk("branch_taken", branch_taken, e.taken);
         chk("branch_target", branch_target, e.target);
         chk("alu_result", alu_result, e.result);
         chk("store_data", store_data, e.store);
         chk("wreg", wreg, e.wreg);
      end else begin
         chk("bubble", {valid_out, regwriteout, memreadout, memwriteout,
                        memtoregout, branch_taken}, 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t i;
      rst_n = 1'b0; flush = 1'b0;
      i = rnd_instr(); i.in_valid = 1'b1; i.aluop = 3'd6;
      apply(i);
      #1;
      chk_zero("reset_outputs");
      chk("reset_stall", stall, 0);
      repeat (3) begin
         @(posedge clk); #1;
         apply(rnd_instr());
         in_valid = 1'b1;
         chk_zero("reset_hold");
         chk("reset_hold_stall", stall, 0);
      end
      i = rnd_instr(); i.in_valid = 1'b0;
      apply(i);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk_zero("post_reset_idle");
      end

      // ADD overflow wraps, destination from rd
      i = mk(3'd0, 16'h7FFF, 16'h0001); i.regdst = 1'b1; i.rd2 = 4'd5;
      run(i, -1);
      // signed SLT
      run(mk(3'd4, 16'hFFFF, 16'h0001), -1);
      // multiplies, the second accepted right after the first
      run(mk(3'd6, 16'h0123, 16'h0010), -1);
      run(mk(3'd6, 16'hFFFF, 16'hFFFF), -1);
      // branch taken with wrapping target, then not taken
      i = mk(3'd0, 16'h0042, 16'h0042); i.branch = 1'b1; i.pcplus = 16'h0010; i.offset = 16'hFFFC;
      run(i, -1);
      i.data2 = 16'h0043;
      run(i, -1);
      // MUL flushed at cnt 7, then an ADD with latency 1
      run(mk(3'd6, 16'h1234, 16'h0567), 8);
      chk("flush_stall", stall, 0);
      run(mk(3'd0, 16'h0100, 16'h0023), -1);
      // flush together with a MUL accept: nothing latched
      run(mk(3'd6, 16'h0003, 16'h0005), 0);
      // MUL opcode without in_valid: no accept
      i = mk(3'd6, 16'h0003, 16'h0005); i.in_valid = 1'b0;
      run(i, -1);
      // SLL with immediate operand
      i = mk(3'd5, 16'h0001, 16'h0000); i.alusrc = 1'b1; i.offset = 16'h00F3;
      run(i, -1);

      // reset pulse in the middle of a multiply
      apply(mk(3'd6, 16'h00FF, 16'h00FF));
      repeat (6) begin @(posedge clk); #1; end
      chk("mul_stall_before_reset", stall, 1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset_mid_mul");
      chk("async_reset_stall", stall, 0);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      run(mk(3'd1, 16'h0005, 16'h0007), -1);

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         int fa;
         i = rnd_instr();
         fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1;
         if (i.aluop != 3'd6 || !i.in_valid) fa = (fa >= 0) ? 0 : -1;
         run(i, fa);
      end

      i = rnd_instr(); i.in_valid = 1'b0;
      apply(i);
      repeat (2) begin @(posedge clk); #1; end
      chk("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
